// File: rtl/rx_stream_gen.sv
// rx_stream_gen: multi-channel RX sample generator.
//
// Each channel decimates clk by (rate+1), tags the selected DDS value with a
// running sequence number and pushes the word into its own small FIFO, which
// is drained over an AXI-stream style valid/ready pair. A sample that finds
// the FIFO full (with no pop on the same edge) is dropped and latches the
// channel's sticky overflow flag.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset, whole block
//   ch_rst_n_i     per-channel synchronous active-low clear
//   rate_i         per-channel decimation rate, RATE_WIDTH bits each
//   dds_i          three DDS sources, DDS_WIDTH bits each
//   dds_source_i   per-channel 2-bit source select (3 = constant zero)
//   axis_tready_i  per-channel downstream ready
//   axis_tvalid_o  per-channel FIFO non-empty
//   axis_tdata_o   per-channel head-of-FIFO word {seq, dds}
//   overflow_o     per-channel sticky sample-dropped flag
module rx_stream_gen #(
  parameter int CHANNELS   = 2,
  parameter int RATE_WIDTH = 10,
  parameter int DDS_WIDTH  = 18,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS-1:0]            ch_rst_n_i,
  input  logic [CHANNELS*RATE_WIDTH-1:0] rate_i,
  input  logic [3*DDS_WIDTH-1:0]         dds_i,
  input  logic [CHANNELS*2-1:0]          dds_source_i,
  input  logic [CHANNELS-1:0]            axis_tready_i,
  output logic [CHANNELS-1:0]            axis_tvalid_o,
  output logic [CHANNELS*DATA_WIDTH-1:0] axis_tdata_o,
  output logic [CHANNELS-1:0]            overflow_o
);

  localparam int SEQ_W = DATA_WIDTH - DDS_WIDTH;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [RATE_WIDTH-1:0] cnt;
    logic [SEQ_W-1:0]      seq;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  ovf;

    logic [RATE_WIDTH-1:0] rate;
    logic [1:0]            src;
    logic [DDS_WIDTH-1:0]  dds_sel;
    logic                  gen;
    logic                  full;
    logic                  valid;
    logic                  pop;
    logic                  push_ok;

    assign rate = rate_i[c*RATE_WIDTH +: RATE_WIDTH];
    assign src  = dds_source_i[c*2 +: 2];

    always_comb begin
      dds_sel = '0;
      case (src)
        2'd0:    dds_sel = dds_i[0*DDS_WIDTH +: DDS_WIDTH];
        2'd1:    dds_sel = dds_i[1*DDS_WIDTH +: DDS_WIDTH];
        2'd2:    dds_sel = dds_i[2*DDS_WIDTH +: DDS_WIDTH];
        default: dds_sel = '0;
      endcase
    end

    // >= rather than == so lowering the rate below the running count fires
    // on the next edge instead of waiting for a counter wrap.
    assign gen   = (cnt >= rate);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign valid = (count != '0);
    assign pop   = valid & axis_tready_i[c];
    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign push_ok = gen & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        seq    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (!ch_rst_n_i[c]) begin
        // Storage is left alone; the stale head is don't-care while empty.
        cnt    <= '0;
        seq    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (gen) begin
          cnt <= '0;
          seq <= seq + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end

        if (push_ok) begin
          mem[wr_ptr] <= {seq, dds_sel};
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (gen && !push_ok) ovf <= 1'b1;

        if (pop) rd_ptr <= rd_ptr + 1'b1;

        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    assign axis_tvalid_o[c]                           = valid;
    assign overflow_o[c]                              = ovf;
    assign axis_tdata_o[c*DATA_WIDTH +: DATA_WIDTH]   = mem[rd_ptr];
  end

endmodule

// File: tb/tb_rx_stream_gen.sv
module tb_rx_stream_gen;

  localparam int CH = 2;
  localparam int RW = 10;
  localparam int DW = 18;
  localparam int XW = 32;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     ch_rst_n;
  logic [CH*RW-1:0]  rate;
  logic [3*DW-1:0]   dds;
  logic [CH*2-1:0]   dds_source;
  logic [CH-1:0]     tready;
  logic [CH-1:0]     tvalid;
  logic [CH*XW-1:0]  tdata;
  logic [CH-1:0]     overflow;

  int n_cmp = 0;
  int n_err = 0;
  int n1    = 0;   // edges since block reset release; ch1 streams seq n1-1

  localparam logic [DW-1:0] DDS0 = 18'h01234;
  localparam logic [DW-1:0] DDS1 = 18'h0abcd;
  localparam logic [DW-1:0] DDS2 = 18'h35555;

  rx_stream_gen #(
    .CHANNELS(CH), .RATE_WIDTH(RW), .DDS_WIDTH(DW), .DATA_WIDTH(XW), .FIFO_DEPTH(FD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_rst_n_i   (ch_rst_n),
    .rate_i       (rate),
    .dds_i        (dds),
    .dds_source_i (dds_source),
    .axis_tready_i(tready),
    .axis_tvalid_o(tvalid),
    .axis_tdata_o (tdata),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XW-1:0] word(input int s, input logic [DW-1:0] d);
    logic [XW-DW-1:0] sq;
    sq = s[XW-DW-1:0];
    return {sq, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    n1++;
  endtask

  task automatic pulse_ch0();
    ch_rst_n = 2'b10;
    step();
    ch_rst_n = 2'b11;
  endtask

  task automatic chk_ch1(input string tag);
    chk({tag, "_v1"}, 64'(tvalid[1]), 64'd1);
    chk({tag, "_d1"}, 64'(tdata[XW +: XW]), 64'(word(n1 - 1, DDS1)));
  endtask

  initial begin
    rst_n      = 1'b0;
    ch_rst_n   = 2'b11;
    rate       = {10'd0, 10'd4};
    dds        = {DDS2, DDS1, DDS0};
    dds_source = {2'd1, 2'd0};
    tready     = 2'b11;
    #23;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ch0 rate 4: one word every 5 edges; ch1 rate 0: continuous stream
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("t1_v0", 64'(tvalid[0]), 64'((k % 5) == 0));
      if ((k % 5) == 0) chk("t1_d0", 64'(tdata[0 +: XW]), 64'(word(k / 5 - 1, DDS0)));
      chk_ch1("t1");
    end

    // Overflow: rate 2, no ready for 20 edges; samples at 3,6,...,18
    rate[0 +: RW] = 10'd2;
    tready[0]     = 1'b0;
    pulse_ch0();
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("t2_ovf", 64'(overflow[0]), 64'(k >= 15));
      chk("t2_v0", 64'(tvalid[0]), 64'(k >= 3));
    end
    chk("t2_head", 64'(tdata[0 +: XW]), 64'(word(0, DDS0)));
    tready[0] = 1'b1;
    begin
      int exp_seq[5] = '{1, 2, 3, 6, 7};
      for (int i = 0; i < 5; i++) begin
        step();
        chk("t2_drain", 64'(tdata[0 +: XW]), 64'(word(exp_seq[i], DDS0)));
        chk("t2_ovf_hold", 64'(overflow[0]), 64'd1);
      end
    end

    // Channel clear with overflow set; ch1 must keep streaming
    pulse_ch0();
    chk("t3_v0", 64'(tvalid[0]), 64'd0);
    chk("t3_ovf", 64'(overflow[0]), 64'd0);
    chk_ch1("t3");
    step();
    step();
    chk("t3_v0_early", 64'(tvalid[0]), 64'd0);
    step();
    chk("t3_v0_first", 64'(tvalid[0]), 64'd1);
    chk("t3_d0_first", 64'(tdata[0 +: XW]), 64'(word(0, DDS0)));
    chk_ch1("t3b");

    // Full FIFO at rate 0: pop+push keeps it full without overflow
    rate[0 +: RW] = 10'd0;
    tready[0]     = 1'b0;
    pulse_ch0();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t4_fill_ovf", 64'(overflow[0]), 64'd0);
    end
    tready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t4_xfer", 64'(tdata[0 +: XW]), 64'(word(i, DDS0)));
      step();
      chk("t4_ovf", 64'(overflow[0]), 64'd0);
    end
    tready[0] = 1'b0;
    step();
    chk("t4_drop_ovf", 64'(overflow[0]), 64'd1);
    chk("t4_hold", 64'(tdata[0 +: XW]), 64'(word(6, DDS0)));

    // Rate lowered below the running count
    rate[0 +: RW] = 10'd100;
    tready[0]     = 1'b1;
    pulse_ch0();
    for (int k = 1; k <= 50; k++) step();
    chk("t5_idle", 64'(tvalid[0]), 64'd0);
    rate[0 +: RW] = 10'd10;
    for (int k = 51; k <= 73; k++) begin
      step();
      chk("t5_v0", 64'(tvalid[0]), 64'(k == 51 || k == 62 || k == 73));
      if (k == 51 || k == 62 || k == 73)
        chk("t5_d0", 64'(tdata[0 +: XW]), 64'(word((k - 51) / 11, (k == 73) ? 18'd0 : DDS0)));
      if (k == 62) dds_source[1:0] = 2'd3;
    end
    chk_ch1("t5");

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 64'(tvalid), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_tdata", 64'(tdata), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
